gpio_cnf_bank: RTL
==================

// Module: gpio_cnf_bank
// PURPOSE
//  Parametrised bank of NUM_CH GPIO configuration/status register pairs on a simple rd/wr bus.
//  Each channel holds a SIZE-bit config word and a sticky NEWDATA flag set by a hardware pulse.
//  Each channel adds an overrun flag, a saturating event counter and a maskable interrupt.
//  Sits between the core's peripheral bus decoder and the GPIO pin logic; cnf_out drives the pins.
// PARAMETERS
//  NUM_CH  4   number of channels (1..16)
//  SIZE    32  config/status word width (>= CNT_W+2)
//  CNT_W   8   event counter width; counter saturates at 2^CNT_W-1
//  ADDR_W  $clog2(NUM_CH)+1  derived: addr = {ch, sel}; sel=addr[0]
// PORTS
//  clk      in   1              single clock, all state on rising edge
//  rst      in   1              synchronous, active-low reset
//  wr       in   1              write strobe, one cycle per access
//  rd       in   1              read strobe, one cycle per access
//  addr     in   ADDR_W         {channel, sel}; sel 0 = CNF, 1 = STATUS
//  wdata    in   SIZE           write data
//  new_data in   NUM_CH         per-channel one-cycle hardware event pulse
//  rdata    out  SIZE           read data, registered
//  rvalid   out  1              rdata valid, one cycle
//  addr_err out  1              one-cycle pulse: access to channel >= NUM_CH or wr to STATUS
//  irq      out  NUM_CH         per-channel interrupt = CNF.IE & NEWDATA
//  irq_any  out  1              OR of irq
//  cnf_out  out  NUM_CH*SIZE    flattened CNF words, channel 0 in LSBs
// BEHAVIOUR
//  Reset (rst==0 at clk edge): all CNF, flags, counters, rdata, rvalid, addr_err = 0; irq = 0.
//  CNF[ch] layout: bit0 IE (RW); bit1 NEWDATA (read = flag, write 1 clears, write 0 no effect);
//   bits [SIZE-1:2] plain RW. cnf_out carries the live word including NEWDATA in bit1.
//  STATUS[ch] (RO): bit0 NEWDATA, bit1 OVERRUN, [CNT_W+1:2] COUNT, rest 0.
//  new_data[ch]=1: NEWDATA<=1; if NEWDATA already 1, OVERRUN<=1; COUNT<=COUNT+1 unless saturated.
//  Write CNF: updates IE and [SIZE-1:2] next edge; W1C on bit1 effective next edge.
//  Simultaneous new_data and W1C of NEWDATA: set wins (NEWDATA stays 1; OVERRUN set only if
//   NEWDATA was 1 before the edge). Other bits of the write still take effect.
//  Read: rdata/rvalid one cycle after rd (latency 1). Read of STATUS returns pre-clear value,
//   then clears OVERRUN and COUNT on same edge; NEWDATA unaffected.
//  Read-clear with simultaneous new_data: COUNT<=1, OVERRUN<=(NEWDATA before edge).
//  rd and wr same cycle: write applied, read returns pre-write value.
//  Invalid access (ch>=NUM_CH, or wr to STATUS): no state change, read data 0, rvalid still 1
//   for reads, addr_err=1 for one cycle.
//  irq is combinational from registered state: asserts the cycle after the setting edge.
//  rst low mid-access: access discarded, all state to reset values.
// STRUCTURE
//  Package gpio_cnf_pkg: SEL_CNF/SEL_STATUS codes, bit indices IE_BIT=0, ND_BIT=1, OVR_BIT=1,
//   CNT_LSB=2.
//  Sub-module gpio_cnf_channel: one CNF word, flags, counter, irq; instantiated NUM_CH times via
//   generate; top holds address decode, read mux, rdata/rvalid/addr_err registers.
// TESTING
//  1 Reset: hold rst=0 3 cycles with wr=1 -> all outputs 0, cnf_out=0 after release.
//  2 wr CNF ch2 0xA5A5_A5A7 -> cnf_out[95:64]=0xA5A5_A5A5 (bit1 W1C, no set); read next cycle
//    -> rdata=0xA5A5_A5A5, rvalid=1 one cycle after rd.
//  3 IE=1 on ch0, pulse new_data[0] twice -> irq[0]=1, irq_any=1, STATUS read=0x0000_000B
//    (COUNT=2,OVR=1,ND=1); second STATUS read=0x0000_0001.
//  4 Same-cycle new_data[1] and wr CNF ch1 bit1=1 with ND=0 -> ND=1, OVR=0; repeat with ND=1
//    -> ND=1, OVR=1.
//  5 CNT_W=8: 300 pulses on ch3 -> COUNT=255; read-clear same cycle as pulse -> next COUNT=1.
//  6 NUM_CH=3: rd addr {ch=3,sel=0} -> rdata=0, rvalid=1, addr_err=1; wr STATUS -> addr_err=1,
//    no state change.

Source files
------------

// File: rtl/gpio_cnf_pkg.sv
// Shared codes and bit positions for the GPIO configuration/status register bank.
package gpio_cnf_pkg;

  typedef enum logic {
    SEL_CNF    = 1'b0,
    SEL_STATUS = 1'b1
  } sel_e;

  // CNF word bits
  localparam int IE_BIT    = 0;
  localparam int ND_BIT    = 1;
  // STATUS word bits
  localparam int ST_ND_BIT = 0;
  localparam int OVR_BIT   = 1;
  localparam int CNT_LSB   = 2;

endpackage

// File: rtl/gpio_cnf_bank_if.sv
// Register bus between the peripheral decoder (master) and the GPIO bank (slave).
interface gpio_cnf_bank_if #(
  parameter int ADDR_W = 3,
  parameter int SIZE   = 32
);

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [SIZE-1:0]   wdata;
  logic [SIZE-1:0]   rdata;
  logic              rvalid;
  logic              addr_err;

  modport master (
    output wr, rd, addr, wdata,
    input  rdata, rvalid, addr_err
  );

  modport slave (
    input  wr, rd, addr, wdata,
    output rdata, rvalid, addr_err
  );

endinterface

// File: rtl/gpio_cnf_channel.sv
// One GPIO channel: CNF word with sticky NEWDATA, overrun flag, saturating event counter, irq.
module gpio_cnf_channel
  import gpio_cnf_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_cnf,
  input  logic            rd_status,
  input  logic            new_data,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] cnf,
  output logic [SIZE-1:0] status,
  output logic            irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             ie_reg, ie_next;
  logic             nd_reg, nd_next;
  logic             ovr_reg, ovr_next;
  logic [SIZE-1:2]  hi_reg, hi_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Hardware event is evaluated last so it wins over both W1C and read-clear.
  always_comb begin
    ie_next  = ie_reg;
    hi_next  = hi_reg;
    nd_next  = nd_reg;
    ovr_next = ovr_reg;
    cnt_next = cnt_reg;
    if (wr_cnf) begin
      ie_next = wdata[IE_BIT];
      hi_next = wdata[SIZE-1:2];
      if (wdata[ND_BIT]) nd_next = 1'b0;
    end
    if (rd_status) begin
      ovr_next = 1'b0;
      cnt_next = '0;
    end
    if (new_data) begin
      nd_next = 1'b1;
      if (nd_reg) ovr_next = 1'b1;
      if (cnt_next != CNT_MAX) cnt_next = cnt_next + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ie_reg  <= 1'b0;
      hi_reg  <= '0;
      nd_reg  <= 1'b0;
      ovr_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      ie_reg  <= ie_next;
      hi_reg  <= hi_next;
      nd_reg  <= nd_next;
      ovr_reg <= ovr_next;
      cnt_reg <= cnt_next;
    end
  end

  assign cnf = {hi_reg, nd_reg, ie_reg};
  assign irq = ie_reg & nd_reg;

  always_comb begin
    status                     = '0;
    status[ST_ND_BIT]          = nd_reg;
    status[OVR_BIT]            = ovr_reg;
    status[CNT_LSB +: CNT_W]   = cnt_reg;
  end

endmodule

// File: rtl/gpio_cnf_bank.sv
// Bank of NUM_CH GPIO channels: address decode, registered read mux and error pulse.
module gpio_cnf_bank
  import gpio_cnf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SIZE   = 32,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  gpio_cnf_bank_if.slave         bus,
  input  logic [NUM_CH-1:0]      new_data,
  output logic [NUM_CH-1:0]      irq,
  output logic                   irq_any,
  output logic [NUM_CH*SIZE-1:0] cnf_out
);

  localparam int ADDR_W = $clog2(NUM_CH) + 1;

  logic [ADDR_W-1:0] ch_idx;
  sel_e              sel;
  logic              ch_ok;
  logic              acc_err;
  logic [SIZE-1:0]   cnf_w    [NUM_CH];
  logic [SIZE-1:0]   status_w [NUM_CH];
  logic [SIZE-1:0]   rdata_reg, rdata_next;
  logic              rvalid_reg;
  logic              addr_err_reg;

  assign ch_idx = bus.addr >> 1;
  assign sel    = sel_e'(bus.addr[0]);
  assign ch_ok  = (ch_idx < ADDR_W'(NUM_CH));
  // A flagged access is dropped entirely, including a read's side effects.
  assign acc_err = (bus.rd | bus.wr) & (~ch_ok | (bus.wr & (sel == SEL_STATUS)));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic hit;
    assign hit = ~acc_err & (ch_idx == ADDR_W'(gi));

    gpio_cnf_channel #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_cnf    (hit & bus.wr & (sel == SEL_CNF)),
      .rd_status (hit & bus.rd & (sel == SEL_STATUS)),
      .new_data  (new_data[gi]),
      .wdata     (bus.wdata),
      .cnf       (cnf_w[gi]),
      .status    (status_w[gi]),
      .irq       (irq[gi])
    );

    assign cnf_out[gi*SIZE +: SIZE] = cnf_w[gi];
  end

  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!acc_err && ch_idx == ADDR_W'(i)) begin
        rdata_next = (sel == SEL_STATUS) ? status_w[i] : cnf_w[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      rvalid_reg   <= bus.rd;
      addr_err_reg <= acc_err;
      if (bus.rd) rdata_reg <= rdata_next;
    end
  end

  assign bus.rdata    = rdata_reg;
  assign bus.rvalid   = rvalid_reg;
  assign bus.addr_err = addr_err_reg;
  assign irq_any      = |irq;

endmodule
